// File: rtl/sc_posregister_jug1.sv
// -----------------------------------------------------------------------------
// sc_posregister_jug1
//
// Player-1 horizontal position register. The position is held as a one-hot
// column bus, and the row comparators consume that bus directly. Left moves the
// set bit toward the MSB and right moves it toward the LSB. Moves stop at the
// board edges and never wrap. A restart puts the player back on START_COL.
//
// Build option:
//   SC_PosREGISTER_JUG1_AUTOREPEAT_EN
//     defined   : a held button repeats its move every REPEAT_CYCLES clocks.
//     undefined : exactly one move per press; the repeat counter is not built.
//   The port list is identical in both builds.
//
// Ports:
//   SC_PosREGISTER_JUG1_CLOCK_50      in   1   system clock, rising edge
//   SC_PosREGISTER_JUG1_RESET_InHigh  in   1   asynchronous reset, active-high
//   SC_PosREGISTER_JUG1_left_InLow    in   1   left button, active-low (clean)
//   SC_PosREGISTER_JUG1_right_InLow   in   1   right button, active-low (clean)
//   SC_PosREGISTER_JUG1_enable        in   1   1 = moves allowed, 0 = frozen
//   SC_PosREGISTER_JUG1_restart       in   1   synchronous return to START_COL
//   SC_PosREGISTER_JUG1_posjug1_Out   out  DW  one-hot position (bit i = col i)
//   SC_PosREGISTER_JUG1_moved_Out     out  1   one-cycle strobe per move
//   SC_PosREGISTER_JUG1_edgeL_Out     out  1   position at bit DATAWIDTH-1
//   SC_PosREGISTER_JUG1_edgeR_Out     out  1   position at bit 0
//
// Timing: a press edge sampled at clock edge n updates the position and the
// moved strobe at that same edge. Both are therefore visible during cycle n+1.
// -----------------------------------------------------------------------------
module sc_posregister_jug1 #(
  parameter int DATAWIDTH     = 8,
  parameter int START_COL     = 3,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic                 SC_PosREGISTER_JUG1_CLOCK_50,
  input  logic                 SC_PosREGISTER_JUG1_RESET_InHigh,
  input  logic                 SC_PosREGISTER_JUG1_left_InLow,
  input  logic                 SC_PosREGISTER_JUG1_right_InLow,
  input  logic                 SC_PosREGISTER_JUG1_enable,
  input  logic                 SC_PosREGISTER_JUG1_restart,
  output logic [DATAWIDTH-1:0] SC_PosREGISTER_JUG1_posjug1_Out,
  output logic                 SC_PosREGISTER_JUG1_moved_Out,
  output logic                 SC_PosREGISTER_JUG1_edgeL_Out,
  output logic                 SC_PosREGISTER_JUG1_edgeR_Out
);

  localparam logic [DATAWIDTH-1:0] START_POS = DATAWIDTH'(1) << START_COL;

  // Catch bad parameter sets at elaboration time instead of leaving a bus that is not one-hot.
  if (REPEAT_CYCLES < 2 || START_COL < 0 || START_COL >= DATAWIDTH) begin : g_bad_param
    $error("sc_posregister_jug1: illegal START_COL/REPEAT_CYCLES");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

  wire clk = SC_PosREGISTER_JUG1_CLOCK_50;
  wire rst = SC_PosREGISTER_JUG1_RESET_InHigh;

  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] pos_q, pos_d;
  logic                 moved_q, moved_d;
  logic                 edge_l_q, edge_l_d;
  logic                 edge_r_q, edge_r_d;
  logic                 l_prev_q, l_prev_d;
  logic                 r_prev_q, r_prev_d;
  logic                 dir_left_q, dir_left_d;
  logic                 arm_q, arm_d;

`ifdef SC_PosREGISTER_JUG1_AUTOREPEAT_EN
  localparam int               CNT_W    = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0]            cnt_q, cnt_d;
`endif

  logic l_lvl, r_lvl, l_edge, r_edge;
  logic held_lvl, opp_lvl;
  logic do_left, do_right;

  always_comb begin
    l_lvl      = ~SC_PosREGISTER_JUG1_left_InLow;
    r_lvl      = ~SC_PosREGISTER_JUG1_right_InLow;
    // Reset makes the history read as released. arm_q stays low until both
    // buttons have been seen released. Without it, a button held through reset
    // would look like a fresh press on the first clock after reset.
    l_edge     = l_lvl & ~l_prev_q & arm_q;
    r_edge     = r_lvl & ~r_prev_q & arm_q;
    held_lvl   = dir_left_q ? l_lvl : r_lvl;
    opp_lvl    = dir_left_q ? r_lvl : l_lvl;

    state_d    = state_q;
    pos_d      = pos_q;
    moved_d    = 1'b0;
    dir_left_d = dir_left_q;
    do_left    = 1'b0;
    do_right   = 1'b0;
    l_prev_d   = l_lvl;
    r_prev_d   = r_lvl;
    arm_d      = arm_q | (~l_lvl & ~r_lvl);
`ifdef SC_PosREGISTER_JUG1_AUTOREPEAT_EN
    cnt_d      = cnt_q;
`endif

    if (SC_PosREGISTER_JUG1_restart) begin
      // Any press edge in this cycle is dropped. The history above still updates.
      pos_d   = START_POS;
      state_d = IDLE;
`ifdef SC_PosREGISTER_JUG1_AUTOREPEAT_EN
      cnt_d   = '0;
`endif
    end else if (!SC_PosREGISTER_JUG1_enable) begin
      state_d = IDLE;
`ifdef SC_PosREGISTER_JUG1_AUTOREPEAT_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Move only on a lone press. If both buttons are high, nothing moves.
          if (l_edge && !r_lvl) begin
            do_left    = 1'b1;
            dir_left_d = 1'b1;
            state_d    = HELD;
`ifdef SC_PosREGISTER_JUG1_AUTOREPEAT_EN
            cnt_d      = '0;
`endif
          end else if (r_edge && !l_lvl) begin
            do_right   = 1'b1;
            dir_left_d = 1'b0;
            state_d    = HELD;
`ifdef SC_PosREGISTER_JUG1_AUTOREPEAT_EN
            cnt_d      = '0;
`endif
          end
        end
        HELD: begin
          if (!held_lvl || opp_lvl) begin
            state_d = IDLE;
`ifdef SC_PosREGISTER_JUG1_AUTOREPEAT_EN
            cnt_d   = '0;
`endif
          end else begin
`ifdef SC_PosREGISTER_JUG1_AUTOREPEAT_EN
            if (cnt_q == CNT_LAST) begin
              cnt_d    = '0;
              do_left  = dir_left_q;
              do_right = ~dir_left_q;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clamp at the edges. A blocked move changes nothing and gives no strobe.
    if (do_left && !pos_q[DATAWIDTH-1]) begin
      pos_d   = pos_q << 1;
      moved_d = 1'b1;
    end else if (do_right && !pos_q[0]) begin
      pos_d   = pos_q >> 1;
      moved_d = 1'b1;
    end

    edge_l_d = pos_d[DATAWIDTH-1];
    edge_r_d = pos_d[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pos_q      <= START_POS;
      moved_q    <= 1'b0;
      edge_l_q   <= START_POS[DATAWIDTH-1];
      edge_r_q   <= START_POS[0];
      l_prev_q   <= 1'b0;
      r_prev_q   <= 1'b0;
      dir_left_q <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      moved_q    <= moved_d;
      edge_l_q   <= edge_l_d;
      edge_r_q   <= edge_r_d;
      l_prev_q   <= l_prev_d;
      r_prev_q   <= r_prev_d;
      dir_left_q <= dir_left_d;
      arm_q      <= arm_d;
    end
  end

`ifdef SC_PosREGISTER_JUG1_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign SC_PosREGISTER_JUG1_posjug1_Out = pos_q;
  assign SC_PosREGISTER_JUG1_moved_Out   = moved_q;
  assign SC_PosREGISTER_JUG1_edgeL_Out   = edge_l_q;
  assign SC_PosREGISTER_JUG1_edgeR_Out   = edge_r_q;

endmodule
